// File: rtl/pri_enc_pkg.sv
// Shared constants and index helpers for the registered priority encoder.
package pri_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Decrement an index with wrap at n instead of at a power of two.
  function automatic int idx_dec_wrap(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/pri_rr_find.sv
// Combinational rotating priority search: bit 'start' has top priority,
// then start-1 down to 0, then N-1 down to start+1.
module pri_rr_find #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] d,
  input  logic [W-1:0] start,
  output logic [W-1:0] q,
  output logic         v,
  output logic [N-1:0] g
);

  localparam logic [W:0]   N_EXT = (W+1)'(N);
  localparam logic [N-1:0] ONE   = N'(1);

  logic [W:0]     shift_amt;
  logic [2*N-1:0] dd;
  logic [N-1:0]   rot;
  logic [W-1:0]   hit;
  logic [W:0]     sum;
  logic [W:0]     sum_wrap;

  always_comb begin
    // Rotate right by start+1 so d[start] lands at position N-1.
    shift_amt = {1'b0, start} + 1'b1;
    dd        = {d, d} >> shift_amt;
    rot       = dd[N-1:0];
    hit       = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) hit = W'(j);
    end
    v        = |rot;
    // Undo the rotation; the sum never reaches 2N so one subtraction wraps it.
    sum      = {1'b0, hit} + {1'b0, start} + 1'b1;
    sum_wrap = (sum >= N_EXT) ? (sum - N_EXT) : sum;
    q        = v ? sum_wrap[W-1:0] : '0;
    g        = v ? (ONE << q) : '0;
  end

endmodule

// File: rtl/pri_enc_rr.sv
// Registered priority encoder with optional round-robin priority and
// valid/ready handshakes on both sides.
module pri_enc_rr
  import pri_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = $clog2(N)
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         v,
  output logic [N-1:0] g,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] PTR_INIT = W'(N - 1);

  logic         out_valid_reg;
  logic [W-1:0] q_reg;
  logic         v_reg;
  logic [N-1:0] g_reg;
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  logic [W-1:0] start;
  logic [W-1:0] find_q;
  logic         find_v;
  logic [N-1:0] find_g;
  logic         accept;

  // Fixed mode is the rotating search with the top priority pinned at N-1.
  assign start = (MODE == MODE_RR) ? ptr_reg : PTR_INIT;

  pri_rr_find #(.N(N)) u_find (
    .d     (d),
    .start (start),
    .q     (find_q),
    .v     (find_v),
    .g     (find_g)
  );

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ptr_next = ptr_reg;
    if (MODE == MODE_RR && accept && find_v) begin
      ptr_next = W'(idx_dec_wrap(int'(find_q), N));
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      v_reg         <= 1'b0;
      g_reg         <= '0;
      ptr_reg       <= PTR_INIT;
    end else begin
      ptr_reg <= ptr_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        q_reg         <= find_q;
        v_reg         <= find_v;
        g_reg         <= find_g;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign q         = q_reg;
  assign v         = v_reg;
  assign g         = g_reg;
  assign ptr       = ptr_reg;

endmodule

// File: tb/tb_pri_enc_rr.sv
// Bench for pri_enc_rr: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) share the handshake and are checked against a scoreboard.
module tb_pri_enc_rr;

  logic       Clock;
  logic       Reset_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] d;

  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic [2:0] q0, q1, q2;
  logic       v0, v1, v2;
  logic [7:0] g0, g1;
  logic [4:0] g2;
  logic [2:0] p0, p1, p2;

  pri_enc_rr #(.N(8), .MODE(0)) dut_f8 (
    .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(ir0),
    .d(d), .out_valid(ov0), .out_ready(out_ready), .q(q0), .v(v0), .g(g0), .ptr(p0)
  );
  pri_enc_rr #(.N(8), .MODE(1)) dut_r8 (
    .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(ir1),
    .d(d), .out_valid(ov1), .out_ready(out_ready), .q(q1), .v(v1), .g(g1), .ptr(p1)
  );
  pri_enc_rr #(.N(5), .MODE(1)) dut_r5 (
    .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(ir2),
    .d(d[4:0]), .out_valid(ov2), .out_ready(out_ready), .q(q2), .v(v2), .g(g2), .ptr(p2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] q;
    logic       v;
    logic [7:0] g;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t sb[$];
  exp3_t cur;
  int    mp [3];
  int    dn [3] = '{8, 8, 5};
  int    dm [3] = '{0, 1, 1};
  logic  model_ov;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  logic       ir_a [3];
  logic       ov_a [3];
  logic [2:0] q_a  [3];
  logic       v_a  [3];
  logic [7:0] g_a  [3];
  logic [2:0] p_a  [3];

  assign ir_a[0] = ir0; assign ir_a[1] = ir1; assign ir_a[2] = ir2;
  assign ov_a[0] = ov0; assign ov_a[1] = ov1; assign ov_a[2] = ov2;
  assign q_a[0]  = q0;  assign q_a[1]  = q1;  assign q_a[2]  = q2;
  assign v_a[0]  = v0;  assign v_a[1]  = v1;  assign v_a[2]  = v2;
  assign g_a[0]  = g0;  assign g_a[1]  = g1;  assign g_a[2]  = {3'b000, g2};
  assign p_a[0]  = p0;  assign p_a[1]  = p1;  assign p_a[2]  = p2;

  task automatic chk(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference search: walk the priority order and take the first set bit.
  task automatic model(input int n, input int m, input int dv, inout int p,
                       output int qq, output int vv, output int gg);
    int top;
    int idx;
    qq  = 0;
    vv  = 0;
    gg  = 0;
    dv  = dv & ((1 << n) - 1);
    top = (m == 1) ? p : n - 1;
    for (int k = 0; k < n; k++) begin
      idx = (top - k + n) % n;
      if (vv == 0 && ((dv >> idx) & 1) == 1) begin
        qq = idx;
        vv = 1;
      end
    end
    if (vv == 1) gg = 1 << qq;
    if (vv == 1 && m == 1) p = (qq == 0) ? n - 1 : qq - 1;
  endtask

  task automatic compare_outputs(input string ph);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out_valid%0d", ph, i), ov_a[i], model_ov);
      chk($sformatf("%s_ptr%0d", ph, i), p_a[i], mp[i]);
      if (model_ov) begin
        chk($sformatf("%s_q%0d", ph, i), q_a[i], cur[i].q);
        chk($sformatf("%s_v%0d", ph, i), v_a[i], cur[i].v);
        chk($sformatf("%s_g%0d", ph, i), g_a[i], cur[i].g);
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check after the next one.
  task automatic cycle(input string ph, input logic iv, input logic [7:0] dv, input logic orr);
    logic  acc;
    int    qq, vv, gg;
    exp3_t e;
    in_valid  = iv;
    d         = dv;
    out_ready = orr;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_in_ready%0d", ph, i), ir_a[i], (!model_ov || orr));
    acc = iv && (!model_ov || orr);
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        model(dn[i], dm[i], int'(dv), mp[i], qq, vv, gg);
        e[i].q = 3'(qq);
        e[i].v = vv[0];
        e[i].g = 8'(gg);
      end
      sb.push_back(e);
    end
    @(posedge Clock);
    if (acc) model_ov = 1'b1;
    else if (orr) model_ov = 1'b0;
    @(negedge Clock);
    if (acc) begin
      if (sb.size() == 0) chk({ph, "_sb_empty"}, 1, 0);
      else cur = sb.pop_front();
    end
    $display("%s iv=%0b d=%02h or=%0b acc=%0b q=%0d/%0d/%0d ptr=%0d/%0d/%0d",
             ph, iv, dv, orr, acc, q0, q1, q2, p0, p1, p2);
    compare_outputs(ph);
  endtask

  task automatic model_reset();
    model_ov = 1'b0;
    cur      = '0;
    sb.delete();
    for (int i = 0; i < 3; i++) mp[i] = dn[i] - 1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), ir_a[i], 1);
      chk($sformatf("rst_q%0d", i), q_a[i], 0);
      chk($sformatf("rst_v%0d", i), v_a[i], 0);
      chk($sformatf("rst_g%0d", i), g_a[i], 0);
    end
    compare_outputs("rst");
    Reset_n = 1'b1;
    @(negedge Clock);

    // Basic encode, then an all-zero request.
    cycle("basic", 1'b1, 8'b0010_0110, 1'b1);
    cycle("zero",  1'b1, 8'h00, 1'b1);

    // Full request held: round-robin walks 7..0 and wraps.
    for (int k = 0; k < 9; k++) cycle("full", 1'b1, 8'hFF, 1'b1);

    // Ends and wrap behaviour with only the outermost bits set.
    cycle("edge", 1'b1, 8'b1000_0001, 1'b1);
    cycle("edge", 1'b1, 8'b1000_0001, 1'b1);

    // Back-pressure: result held for three cycles, next request waits.
    cycle("bp_load", 1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 3; k++) cycle("bp_hold", 1'b1, 8'h3C, 1'b0);
    cycle("bp_swap", 1'b1, 8'h3C, 1'b1);
    cycle("idle", 1'b0, 8'h00, 1'b1);

    // Reset mid-operation with a pending result.
    model_reset();
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle("prerst", 1'b1, 8'hFF, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_q%0d", i), q_a[i], 0);
      chk($sformatf("arst_v%0d", i), v_a[i], 0);
      chk($sformatf("arst_g%0d", i), g_a[i], 0);
      chk($sformatf("arst_in_ready%0d", i), ir_a[i], 1);
    end
    compare_outputs("arst");
    @(negedge Clock);
    Reset_n = 1'b1;
    cycle("postrst", 1'b1, 8'h81, 1'b1);
    cycle("postrst", 1'b1, 8'h81, 1'b1);

    // Random traffic with random back-pressure.
    for (int k = 0; k < 60; k++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    cycle("drain", 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
